// File: rtl/core_hazard_pkg.sv
// Shared types for the load hazard scoreboard: register address and queue entry.
// Consumed by both the tag FIFO and the scoreboard top.
package core_hazard_pkg;

    localparam int REG_W = 5;

    typedef logic [REG_W-1:0] reg_addr_t;

    typedef struct packed {
        logic      valid;
        reg_addr_t rd;
    } sb_entry_t;

endpackage

// File: rtl/sb_tag_fifo.sv
// Circular queue of in-flight load rd tags; entry array exported for hazard compare.
// Latency: push/pop visible one cycle later; head_rd, count, full and empty are combinational from state.
// Backpressure: none internally; the caller gates push against full and pop against empty.
module sb_tag_fifo
    import core_hazard_pkg::*;
#(
    parameter  int MAX_OUT = 4,
    localparam int AW      = $clog2(MAX_OUT),
    localparam int PW      = AW + 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  reg_addr_t   push_rd,
    input  logic        pop,
    output sb_entry_t   entries [MAX_OUT],
    output reg_addr_t   head_rd,
    output logic [PW-1:0] count,
    output logic        full,
    output logic        empty
);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    sb_entry_t     mem [MAX_OUT];

    // Pop clears before push sets, so a push into the slot freed this cycle wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < MAX_OUT; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (pop) begin
                mem[rd_ptr[AW-1:0]].valid <= 1'b0;
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= '{valid: 1'b1, rd: push_rd};
                wr_ptr <= wr_ptr + PW'(1);
            end
        end
    end

    assign entries = mem;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign head_rd = empty ? '0 : mem[rd_ptr[AW-1:0]].rd;

endmodule

// File: rtl/load_scoreboard.sv
// Decode-stage hazard tracker for in-flight AXI loads (RAW, WAW, structural); optional stats via LOAD_SCOREBOARD_STATS_EN.
// Latency: issue/retire at cycle N affect stall at N+1; stall is combinational from registered state and decode inputs.
// Backpressure: stall holds decode; an issue while full without a retire is dropped and flagged in proto_err.
module load_scoreboard
    import core_hazard_pkg::*;
#(
    parameter  int MAX_OUT = 4,
    localparam int CW      = $clog2(MAX_OUT) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    input  logic [REG_W-1:0] issue_rd,
    input  logic             resp_valid,
    input  logic [REG_W-1:0] dec_rs1,
    input  logic [REG_W-1:0] dec_rs2,
    input  logic             dec_rs1_used,
    input  logic             dec_rs2_used,
    input  logic [REG_W-1:0] dec_rd,
    input  logic             dec_rd_wr,
    input  logic             dec_is_load,
    output logic             stall,
    output logic [REG_W-1:0] wb_rd,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             proto_err,
    output logic [31:0]      stall_cycles
);

    sb_entry_t entries [MAX_OUT];
    logic      do_push;
    logic      do_pop;
    logic      raw_hit;
    logic      waw_hit;

    // A retire in the same cycle frees the slot, so a full queue still accepts the issue.
    assign do_pop  = resp_valid && !empty;
    assign do_push = issue_valid && (!full || resp_valid);

    sb_tag_fifo #(.MAX_OUT(MAX_OUT)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (do_push),
        .push_rd (issue_rd),
        .pop     (do_pop),
        .entries (entries),
        .head_rd (wb_rd),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    // x0 never creates a hazard, so zero-valued decode registers are excluded.
    always_comb begin
        raw_hit = 1'b0;
        waw_hit = 1'b0;
        for (int i = 0; i < MAX_OUT; i++) begin
            if (entries[i].valid) begin
                if (dec_rs1_used && (dec_rs1 != '0) && (entries[i].rd == dec_rs1)) raw_hit = 1'b1;
                if (dec_rs2_used && (dec_rs2 != '0) && (entries[i].rd == dec_rs2)) raw_hit = 1'b1;
                if (dec_rd_wr && (dec_rd != '0) && (entries[i].rd == dec_rd))      waw_hit = 1'b1;
            end
        end
        stall = raw_hit || waw_hit || (dec_is_load && full);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            proto_err <= 1'b0;
        end else if ((issue_valid && full && !resp_valid) || (resp_valid && empty)) begin
            proto_err <= 1'b1;
        end
    end

`ifdef LOAD_SCOREBOARD_STATS_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign stall_cycles = stall_cnt;
`else
    assign stall_cycles = '0;
`endif

endmodule
